hazard_tracker: RTL

Pipeline hazard tracker for the 5-stage MIPS core, sitting directly downstream of the ID-stage Tuse/Tnew decoder. It consumes the decoded per-instruction Tuse/Tnew and register numbers, and carries each in-flight producer's destination and remaining Tnew through E/M/W. From that state it raises the D-stage stall and drives the forwarding-mux selects for the D, E and M stages. It is control only; the datapath muxes live in the stages.

---
 rtl/hazard_tracker.sv | 75 +++++++
 1 files changed

// File: rtl/hazard_tracker.sv
// hazard_tracker: D-stage stall and D/E/M forwarding selects from E/M/W producer tracking; forwarding built only with `HAZARD_FWD_EN
module hazard_tracker #(
  parameter int REG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       tuse_rs_D,
  input  logic [1:0]       tuse_rt_D,
  input  logic [1:0]       tnew_D,
  input  logic [REG_W-1:0] rs_D,
  input  logic [REG_W-1:0] rt_D,
  input  logic [REG_W-1:0] dst_D,
  output logic             stall,
  output logic [1:0]       fwd_rs_D,
  output logic [1:0]       fwd_rt_D,
  output logic [1:0]       fwd_rs_E,
  output logic [1:0]       fwd_rt_E,
  output logic             fwd_rt_M
);
  logic [REG_W-1:0] rs_E, rt_E, dst_E, rt_M, dst_M, dst_W;
  logic [1:0] tnew_E, tnew_M;
  logic rs_e, rs_m, rt_e, rt_m;
  function automatic logic hit(input logic [REG_W-1:0] s, input logic [REG_W-1:0] d);
    return s != '0 && s == d;
  endfunction
  assign rs_e = hit(rs_D, dst_E);
  assign rs_m = hit(rs_D, dst_M);
  assign rt_e = hit(rt_D, dst_E);
  assign rt_m = hit(rt_D, dst_M);
  // Advance producers through E/M/W; a stall turns the E slot into a bubble.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rs_E   <= '0;
      rt_E   <= '0;
      dst_E  <= '0;
      tnew_E <= '0;
      rt_M   <= '0;
      dst_M  <= '0;
      tnew_M <= '0;
      dst_W  <= '0;
    end else begin
      rs_E   <= stall ? '0 : rs_D;
      rt_E   <= stall ? '0 : rt_D;
      dst_E  <= stall ? '0 : dst_D;
      tnew_E <= stall ? 2'd0 : tnew_D;
      rt_M   <= rt_E;
      dst_M  <= dst_E;
      tnew_M <= tnew_E == 2'd0 ? 2'd0 : tnew_E - 2'd1;
      dst_W  <= dst_M;
    end
`ifdef HAZARD_FWD_EN
  logic rs_w, rt_w;
  assign rs_w = hit(rs_D, dst_W);
  assign rt_w = hit(rt_D, dst_W);
  // Stall only while a matching producer's result arrives later than the consumer needs it.
  assign stall = (rs_e && tnew_E > tuse_rs_D) || (rs_m && tnew_M > tuse_rs_D) ||
                 (rt_e && tnew_E > tuse_rt_D) || (rt_m && tnew_M > tuse_rt_D);
  // Youngest ready producer wins; a not-yet-ready match falls through since the stall covers it.
  assign fwd_rs_D = rs_e && tnew_E == 2'd0 ? 2'd3 : rs_m && tnew_M == 2'd0 ? 2'd2 : rs_w ? 2'd1 : 2'd0;
  assign fwd_rt_D = rt_e && tnew_E == 2'd0 ? 2'd3 : rt_m && tnew_M == 2'd0 ? 2'd2 : rt_w ? 2'd1 : 2'd0;
  assign fwd_rs_E = hit(rs_E, dst_M) && tnew_M == 2'd0 ? 2'd2 : hit(rs_E, dst_W) ? 2'd1 : 2'd0;
  assign fwd_rt_E = hit(rt_E, dst_M) && tnew_M == 2'd0 ? 2'd2 : hit(rt_E, dst_W) ? 2'd1 : 2'd0;
  assign fwd_rt_M = hit(rt_M, dst_W);
`else
  logic unused_nofwd;
  // Without bypass paths any in-flight E/M producer of a used source blocks D; W is covered by the regfile.
  assign stall = ((rs_e || rs_m) && tuse_rs_D != 2'd3) || ((rt_e || rt_m) && tuse_rt_D != 2'd3);
  assign fwd_rs_D = '0;
  assign fwd_rt_D = '0;
  assign fwd_rs_E = '0;
  assign fwd_rt_E = '0;
  assign fwd_rt_M = 1'b0;
  assign unused_nofwd = ^{rs_E, rt_M, dst_W, tnew_M};
`endif
endmodule
